// File: rtl/bomb_game_top.sv
// Defuse-the-bomb game: button front end, lives/timer FSM, seven-segment and TFT serial links.
// Define AUDIO_EN to build the tone generator; otherwise audio is tied low.
module bomb_game_top #(
    parameter int CLK_HZ    = 12000000,
    parameter int START_SEC = 300,
    parameter int SCK_DIV   = 4,
    parameter int TONE_DIV  = 6000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] button,
    output logic       ssdec_sdi,
    output logic       ssdec_ss,
    output logic       ssdec_sck,
    output logic       tft_sck,
    output logic       tft_sdi,
    output logic       tft_dc,
    output logic       tft_rst,
    output logic       tft_cs,
    output logic [2:0] tft_state,
    output logic       audio
);
    typedef enum logic [1:0] {MENU = 2'd0, PLAY = 2'd1, LOST = 2'd2, WON = 2'd3} state_t;

    localparam logic [5:0] B_SELECT = 6'b000001;
    localparam logic [5:0] B_UP     = 6'b000010;
    localparam logic [5:0] B_RIGHT  = 6'b000100;
    localparam logic [5:0] B_DOWN   = 6'b001000;
    localparam logic [5:0] B_BACK   = 6'b100000;
    localparam int TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int SCK_W  = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [7:0] RESET_STATUS = 8'h18;

    function automatic logic [5:0] code_at(input logic [1:0] mod, input logic [1:0] step);
        logic [5:0] c;
        case ({mod, step})
            4'b0000: c = B_RIGHT;
            4'b0001: c = B_DOWN;
            4'b0010: c = B_SELECT;
            4'b0100: c = B_RIGHT;
            4'b0101: c = B_RIGHT;
            4'b0110: c = B_UP;
            4'b1000: c = B_RIGHT;
            4'b1001: c = B_UP;
            4'b1010: c = B_RIGHT;
            default: c = 6'b000000;
        endcase
        return c;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0: s = 8'h3F;
            4'd1: s = 8'h06;
            4'd2: s = 8'h5B;
            4'd3: s = 8'h4F;
            4'd4: s = 8'h66;
            4'd5: s = 8'h6D;
            4'd6: s = 8'h7D;
            4'd7: s = 8'h07;
            4'd8: s = 8'h7F;
            4'd9: s = 8'h6F;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    logic [5:0] btn_s1_r, btn_s2_r, btn_prev_r, btn_code_r;
    logic       btn_armed_r, btn_stb_r, btn_onehot_s;
    state_t     state_r;
    logic [1:0] lives_r, module_r, step_r;
    logic [15:0] timer_r;
    logic [TICK_W-1:0] tick_cnt_r;
    logic [5:0] exp_code_s;
    logic       hit_s, win_s, tick_s;
    logic [SCK_W-1:0] sck_cnt_r;
    logic       half_tick_s;
    logic [31:0] frame_s, ss_sh_r;
    logic [4:0] ss_bit_r;
    logic       ss_r, ss_sck_r;
    logic [7:0] status_s, tft_last_r, tft_pend_val_r, tft_sh_r;
    logic [2:0] tft_bit_r;
    logic       tft_pend_r, tft_cs_r, tft_sck_r, tft_dc_r, tft_rst_r;

    always_comb btn_onehot_s = (btn_s2_r != 6'd0) && ((btn_s2_r & (btn_s2_r - 6'd1)) == 6'd0);

    // Synchronize the buttons and emit one strobe per press; re-arm only after release.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_s1_r    <= 6'd0;
            btn_s2_r    <= 6'd0;
            btn_prev_r  <= 6'd0;
            btn_code_r  <= 6'd0;
            btn_armed_r <= 1'b0;
            btn_stb_r   <= 1'b0;
        end else begin
            btn_s1_r   <= button;
            btn_s2_r   <= btn_s1_r;
            btn_prev_r <= btn_s2_r;
            btn_stb_r  <= 1'b0;
            if (btn_s2_r == 6'd0) begin
                btn_armed_r <= 1'b1;
            end else if (btn_armed_r && (btn_s2_r == btn_prev_r)) begin
                btn_armed_r <= 1'b0;
                btn_stb_r   <= btn_onehot_s;
                btn_code_r  <= btn_s2_r;
            end
        end
    end

    // Decode the current press against the expected code of the active module.
    always_comb begin
        exp_code_s = code_at(module_r, step_r);
        hit_s      = btn_stb_r && (btn_code_r == exp_code_s);
        win_s      = hit_s && (module_r == 2'd2) && (step_r == 2'd2);
        tick_s     = (tick_cnt_r == TICK_W'(CLK_HZ - 1));
    end

    // Game FSM; a winning press beats the timer running out in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= MENU;
            lives_r    <= 2'd3;
            timer_r    <= 16'(START_SEC);
            module_r   <= 2'd0;
            step_r     <= 2'd0;
            tick_cnt_r <= '0;
        end else begin
            case (state_r)
                MENU: begin
                    if (btn_stb_r && (btn_code_r == B_SELECT)) begin
                        state_r    <= PLAY;
                        lives_r    <= 2'd3;
                        timer_r    <= 16'(START_SEC);
                        module_r   <= 2'd0;
                        step_r     <= 2'd0;
                        tick_cnt_r <= '0;
                    end
                end
                PLAY: begin
                    if (tick_s) begin
                        tick_cnt_r <= '0;
                        if (timer_r != 16'd0) timer_r <= timer_r - 16'd1;
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TICK_W'(1);
                    end
                    if (win_s) begin
                        state_r <= WON;
                    end else if (hit_s) begin
                        if (step_r == 2'd2) begin
                            module_r <= module_r + 2'd1;
                            step_r   <= 2'd0;
                        end else begin
                            step_r <= step_r + 2'd1;
                        end
                    end else if (btn_stb_r && (btn_code_r == B_BACK)) begin
                        step_r <= 2'd0;
                    end else if (btn_stb_r) begin
                        step_r <= 2'd0;
                        if (lives_r == 2'd1) begin
                            lives_r <= 2'd0;
                            state_r <= LOST;
                        end else begin
                            lives_r <= lives_r - 2'd1;
                        end
                    end
                    if ((tick_s && (timer_r <= 16'd1)) && !win_s) state_r <= LOST;
                end
                LOST, WON: begin
                    if (btn_stb_r) state_r <= MENU;
                end
                default: state_r <= MENU;
            endcase
        end
    end

    // Shared half-period divider for both serial clocks.
    always_ff @(posedge clk) begin
        if (rst) sck_cnt_r <= '0;
        else if (half_tick_s) sck_cnt_r <= '0;
        else sck_cnt_r <= sck_cnt_r + SCK_W'(1);
    end

    always_comb begin
        half_tick_s = (sck_cnt_r == SCK_W'(SCK_DIV - 1));
        frame_s = {seg7(4'(timer_r / 16'd60)), seg7(4'((timer_r % 16'd60) / 16'd10)),
                   seg7(4'(timer_r % 16'd10)), seg7({2'b00, lives_r})};
        status_s = {1'b0, state_r, lives_r, module_r, 1'b0};
    end

    // Seven-segment frames back to back; data moves on sck falling edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_r     <= 1'b1;
            ss_sck_r <= 1'b0;
            ss_sh_r  <= 32'd0;
            ss_bit_r <= 5'd0;
        end else if (half_tick_s) begin
            if (ss_r) begin
                ss_r     <= 1'b0;
                ss_sh_r  <= frame_s;
                ss_bit_r <= 5'd0;
            end else if (!ss_sck_r) begin
                ss_sck_r <= 1'b1;
            end else begin
                ss_sck_r <= 1'b0;
                if (ss_bit_r == 5'd31) begin
                    ss_r    <= 1'b1;
                    ss_sh_r <= 32'd0;
                end else begin
                    ss_bit_r <= ss_bit_r + 5'd1;
                    ss_sh_r  <= {ss_sh_r[30:0], 1'b0};
                end
            end
        end
    end

    // TFT status link; a change seen mid-byte overwrites the pending value.
    always_ff @(posedge clk) begin
        if (rst) begin
            tft_rst_r      <= 1'b0;
            tft_cs_r       <= 1'b1;
            tft_sck_r      <= 1'b0;
            tft_dc_r       <= 1'b0;
            tft_sh_r       <= 8'd0;
            tft_bit_r      <= 3'd0;
            tft_pend_r     <= 1'b0;
            tft_pend_val_r <= 8'd0;
            tft_last_r     <= RESET_STATUS;
        end else begin
            tft_rst_r <= 1'b1;
            if (half_tick_s) begin
                if (tft_cs_r) begin
                    if (tft_pend_r) begin
                        tft_pend_r <= 1'b0;
                        tft_cs_r   <= 1'b0;
                        tft_dc_r   <= 1'b1;
                        tft_sh_r   <= tft_pend_val_r;
                        tft_bit_r  <= 3'd0;
                    end
                end else if (!tft_sck_r) begin
                    tft_sck_r <= 1'b1;
                end else begin
                    tft_sck_r <= 1'b0;
                    if (tft_bit_r == 3'd7) begin
                        tft_cs_r <= 1'b1;
                        tft_dc_r <= 1'b0;
                        tft_sh_r <= 8'd0;
                    end else begin
                        tft_bit_r <= tft_bit_r + 3'd1;
                        tft_sh_r  <= {tft_sh_r[6:0], 1'b0};
                    end
                end
            end
            if (status_s != tft_last_r) begin
                tft_last_r     <= status_s;
                tft_pend_r     <= 1'b1;
                tft_pend_val_r <= status_s;
            end
        end
    end

    assign ssdec_ss  = ss_r;
    assign ssdec_sck = ss_sck_r;
    assign ssdec_sdi = ss_sh_r[31];
    assign tft_cs    = tft_cs_r;
    assign tft_sck   = tft_sck_r;
    assign tft_sdi   = tft_sh_r[7];
    assign tft_dc    = tft_dc_r;
    assign tft_rst   = tft_rst_r;
    assign tft_state = {1'b0, state_r};

`ifdef AUDIO_EN
    localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int DUR_W  = $clog2(CLK_HZ / 2 + 2);
    logic [TONE_W-1:0] tone_cnt_r;
    logic [DUR_W-1:0]  dur_r;
    logic [1:0]        lives_q_r;
    state_t            state_q_r;
    logic              tone_r, audio_r;

    // Tone bursts on errors and on winning, continuous while lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            tone_cnt_r <= '0;
            tone_r     <= 1'b0;
            dur_r      <= '0;
            lives_q_r  <= 2'd3;
            state_q_r  <= MENU;
            audio_r    <= 1'b0;
        end else begin
            lives_q_r <= lives_r;
            state_q_r <= state_r;
            if (tone_cnt_r == TONE_W'(TONE_DIV - 1)) begin
                tone_cnt_r <= '0;
                tone_r     <= ~tone_r;
            end else begin
                tone_cnt_r <= tone_cnt_r + TONE_W'(1);
            end
            if ((state_r == WON) && (state_q_r != WON)) dur_r <= DUR_W'(CLK_HZ / 2);
            else if (lives_r < lives_q_r) dur_r <= DUR_W'(CLK_HZ / 10);
            else if (dur_r != '0) dur_r <= dur_r - DUR_W'(1);
            audio_r <= ((state_r == LOST) || (dur_r != '0)) && tone_r;
        end
    end

    assign audio = audio_r;
`else
    assign audio = 1'b0;
`endif
endmodule

// File: tb/tb_bomb_game_top.sv
// Directed bench for bomb_game_top: press table driven through the game, decoded via the TFT byte and ssdec frame.
module tb_bomb_game_top;
    logic       tb_clk = 1'b0;
    logic       rst;
    logic [5:0] button, btn2;
    logic       ssdec_sdi, ssdec_ss, ssdec_sck, tft_sck, tft_sdi, tft_dc, tft_rst, tft_cs, audio;
    logic [2:0] tft_state;
    logic       s2_sdi, s2_ss, s2_sck, t2_sck, t2_sdi, t2_dc, t2_rst, t2_cs, a2;
    logic [2:0] t2_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0] btn;
        logic [2:0] st;
        logic [7:0] tft;
    } vec_t;
    vec_t vecs[24];

    always #5 tb_clk = ~tb_clk;

    bomb_game_top dut (
        .clk(tb_clk), .rst(rst), .button(button),
        .ssdec_sdi(ssdec_sdi), .ssdec_ss(ssdec_ss), .ssdec_sck(ssdec_sck),
        .tft_sck(tft_sck), .tft_sdi(tft_sdi), .tft_dc(tft_dc), .tft_rst(tft_rst),
        .tft_cs(tft_cs), .tft_state(tft_state), .audio(audio)
    );

    bomb_game_top #(.CLK_HZ(10), .START_SEC(3)) dut2 (
        .clk(tb_clk), .rst(rst), .button(btn2),
        .ssdec_sdi(s2_sdi), .ssdec_ss(s2_ss), .ssdec_sck(s2_sck),
        .tft_sck(t2_sck), .tft_sdi(t2_sdi), .tft_dc(t2_dc), .tft_rst(t2_rst),
        .tft_cs(t2_cs), .tft_state(t2_state), .audio(a2)
    );

    // Receive TFT bytes the way the panel would: sample sdi on sck rising while selected.
    logic [7:0] tft_byte = 8'h00;
    logic [7:0] tft_sh   = 8'h00;
    logic       tft_sck_q = 1'b0;
    int         tft_n = 0;
    always @(negedge tb_clk) begin
        tft_sck_q <= tft_sck;
        if (tft_cs !== 1'b0) begin
            tft_n <= 0;
        end else if (tft_sck && !tft_sck_q) begin
            tft_sh <= {tft_sh[6:0], tft_sdi};
            tft_n  <= tft_n + 1;
            if (tft_n == 7 && tft_dc) tft_byte <= {tft_sh[6:0], tft_sdi};
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic press(input logic [5:0] b);
        @(negedge tb_clk);
        button = b;
        repeat (8) @(negedge tb_clk);
        button = 6'd0;
        repeat (100) @(negedge tb_clk);
    endtask

    task automatic apply_vec(input int i);
        press(vecs[i].btn);
        check($sformatf("vec%0d state", i), {29'd0, tft_state}, {29'd0, vecs[i].st});
        check($sformatf("vec%0d tft byte", i), {24'd0, tft_byte}, {24'd0, vecs[i].tft});
    endtask

    // Grab the next complete seven-segment frame from either instance.
    task automatic capture_frame(input bit which, output logic [31:0] f, output bit ok);
        bit seen_idle, started;
        logic prev, c_ss, c_sck, c_sdi;
        int n;
        seen_idle = 1'b0; started = 1'b0; ok = 1'b0; prev = 1'b0; f = 32'd0; n = 0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge tb_clk);
            c_ss  = which ? s2_ss  : ssdec_ss;
            c_sck = which ? s2_sck : ssdec_sck;
            c_sdi = which ? s2_sdi : ssdec_sdi;
            if (!started) begin
                if (c_ss) seen_idle = 1'b1;
                else if (seen_idle) started = 1'b1;
            end else if (c_sck && !prev) begin
                f = {f[30:0], c_sdi};
                n++;
                if (n == 32) ok = 1'b1;
            end
            prev = c_sck;
        end
    endtask

    logic [31:0] frame;
    bit          fok;

    initial begin
        vecs[0]  = '{6'b000001, 3'd1, 8'h38};
        vecs[1]  = '{6'b000100, 3'd1, 8'h38};
        vecs[2]  = '{6'b001000, 3'd1, 8'h38};
        vecs[3]  = '{6'b000001, 3'd1, 8'h3A};
        vecs[4]  = '{6'b000100, 3'd1, 8'h3A};
        vecs[5]  = '{6'b000100, 3'd1, 8'h3A};
        vecs[6]  = '{6'b000010, 3'd1, 8'h3C};
        vecs[7]  = '{6'b000100, 3'd1, 8'h3C};
        vecs[8]  = '{6'b000010, 3'd1, 8'h3C};
        vecs[9]  = '{6'b000100, 3'd3, 8'h7C};
        vecs[10] = '{6'b000001, 3'd0, 8'h1C};
        vecs[11] = '{6'b000001, 3'd1, 8'h38};
        vecs[12] = '{6'b010000, 3'd1, 8'h30};
        vecs[13] = '{6'b010000, 3'd1, 8'h28};
        vecs[14] = '{6'b010000, 3'd2, 8'h40};
        vecs[15] = '{6'b000001, 3'd0, 8'h00};
        vecs[16] = '{6'b000001, 3'd1, 8'h38};
        vecs[17] = '{6'b000101, 3'd1, 8'h38};
        vecs[18] = '{6'b000100, 3'd1, 8'h38};
        vecs[19] = '{6'b100000, 3'd1, 8'h38};
        vecs[20] = '{6'b000100, 3'd1, 8'h38};
        vecs[21] = '{6'b001000, 3'd1, 8'h38};
        vecs[22] = '{6'b000001, 3'd1, 8'h3A};
        vecs[23] = '{6'b000100, 3'd1, 8'h3A};

        rst = 1'b1; button = 6'd0; btn2 = 6'd0;
        repeat (2) @(posedge tb_clk);
        #1;
        check("reset state", {29'd0, tft_state}, 32'd0);
        check("reset ssdec_ss", {31'd0, ssdec_ss}, 32'd1);
        check("reset ssdec_sck", {31'd0, ssdec_sck}, 32'd0);
        check("reset tft_cs", {31'd0, tft_cs}, 32'd1);
        check("reset audio", {31'd0, audio}, 32'd0);
        check("reset tft_rst low", {31'd0, tft_rst}, 32'd0);
        @(negedge tb_clk);
        rst = 1'b0;
        @(posedge tb_clk);
        #1;
        check("tft_rst release", {31'd0, tft_rst}, 32'd1);
        capture_frame(1'b0, frame, fok);
        check("reset frame done", {31'd0, fok}, 32'd1);
        check("reset frame 5:00 L3", frame, 32'h6D3F3F4F);

        for (int i = 0; i < 24; i++) begin
            apply_vec(i);
            if (i == 14) check("audio lost (no AUDIO_EN)", {31'd0, audio}, 32'd0);
        end

        // Reset in the middle of module 1 must restore everything on the same edge.
        @(negedge tb_clk);
        rst = 1'b1;
        @(posedge tb_clk);
        #1;
        check("midreset state", {29'd0, tft_state}, 32'd0);
        check("midreset tft_rst", {31'd0, tft_rst}, 32'd0);
        check("midreset tft_cs", {31'd0, tft_cs}, 32'd1);
        check("midreset ssdec_ss", {31'd0, ssdec_ss}, 32'd1);
        @(negedge tb_clk);
        rst = 1'b0;
        capture_frame(1'b0, frame, fok);
        check("midreset frame done", {31'd0, fok}, 32'd1);
        check("midreset frame 5:00 L3", frame, 32'h6D3F3F4F);
        for (int i = 0; i < 4; i++) apply_vec(i);

        // Short-timer instance: 3 s at 10 cycles per second.
        @(negedge tb_clk);
        btn2 = 6'b000001;
        repeat (8) @(negedge tb_clk);
        btn2 = 6'd0;
        repeat (12) @(negedge tb_clk);
        check("timeout still playing", {29'd0, t2_state}, 32'd1);
        repeat (30) @(negedge tb_clk);
        check("timeout lost", {29'd0, t2_state}, 32'd2);
        capture_frame(1'b1, frame, fok);
        check("timeout frame done", {31'd0, fok}, 32'd1);
        check("timeout frame 0:00 L3", frame, 32'h3F3F3F4F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bomb_game_top.md
Name: bomb_game_top

Overview:
- Top level of the "defuse the bomb" game: button front end, game FSM with lives, a 3-module code puzzle and a 5:00 countdown.
- Drives a serial seven-segment driver (ssdec_*) with timer and lives.
- Drives a serial TFT link (tft_*) with a status byte, plus an audio square wave.
- Sits directly under the FPGA/ASIC wrapper; all I/O are pins.

Parameters:
- CLK_HZ, 12000000, clock frequency; sets the 1 Hz timer tick.
- START_SEC, 300, countdown start value in seconds.
- SCK_DIV, 4, clk cycles per half period of ssdec_sck and tft_sck.
- TONE_DIV, 6000, clk cycles per half period of the audio tone (1 kHz at 12 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- button  in  6  one-hot: [0]SELECT [1]UP [2]RIGHT [3]DOWN [4]LEFT [5]BACK; 0 = none.
- ssdec_sdi  out  1  seven-segment serial data.
- ssdec_ss  out  1  seven-segment frame select, active low.
- ssdec_sck  out  1  seven-segment serial clock.
- tft_sck  out  1  TFT serial clock.
- tft_sdi  out  1  TFT serial data.
- tft_dc  out  1  TFT data/command; 1 = data.
- tft_rst  out  1  TFT reset, active low.
- tft_cs  out  1  TFT chip select, active low.
- tft_state  out  3  current game state code.
- audio  out  1  square-wave audio.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - state MENU (0), lives 3, timer 300, module 0, step 0.
  - ssdec_ss=1, ssdec_sck=0, ssdec_sdi=0.
  - tft_cs=1, tft_sck=0, tft_sdi=0, tft_dc=0, tft_rst=0 (released to 1 the first cycle after reset deasserts).
  - audio=0.
- Reset mid-game returns to the reset values in the same edge.
- Button front end:
  - 2-FF synchronizer on button.
  - A press is accepted when the synchronized value is nonzero and stable for 2 consecutive cycles after being 0.
  - Produces a 1-cycle strobe plus the latched code.
  - No new strobe until button returns to 0.
  - A non-one-hot value is ignored.
- State encoding: MENU=0, PLAY=1, LOST=2, WON=3.
- MENU:
  - SELECT strobe -> PLAY; load timer=START_SEC, lives=3, module=0, step=0.
  - Other buttons are ignored.
- PLAY: three modules, each a fixed 3-press code.
  - M0 = RIGHT, DOWN, SELECT.
  - M1 = RIGHT, RIGHT, UP.
  - M2 = RIGHT, UP, RIGHT.
  - Correct press: step++. At step 3, module++ and step=0.
  - Completing M2 -> WON.
  - BACK: step=0, no penalty.
  - Any other wrong press: error. lives-- and step=0.
  - Error at lives==1 -> LOST with lives=0.
- Timer in PLAY:
  - Decrements once per CLK_HZ cycles; tick counter clears on entering PLAY.
  - Reaching 0 -> LOST.
  - If a winning press and timer reaching 0 occur in the same cycle, WON takes priority.
- LOST/WON:
  - Timer and lives frozen.
  - Any button strobe -> MENU.
- Display digits from timer:
  - min = timer/60 (0..5).
  - sec_ten = (timer%60)/10.
  - sec_one = timer%10.
- ssdec frame: 32 bits, MSB first, as four segment bytes {min, sec_ten, sec_one, lives}.
  - Segment byte is active-high gfedcba with dp=0.
  - ssdec_ss is low for the whole frame.
  - sdi changes on the falling edge of sck; the device samples on the rising edge.
  - Frames repeat continuously with 1 idle half-period between them.
- TFT link:
  - Whenever {state, lives, module} changes, send one 8-bit data byte {state[2:0], lives[1:0], module[1:0], 0}, MSB first.
  - tft_dc=1 and tft_cs=0 for the byte; same sck timing as ssdec.
  - A change occurring during a transmission is queued (latest value wins).
- tft_state = state at all times.

Optional Feature:
- AUDIO_EN.
- Defined:
  - Each error produces 100 ms of tone (CLK_HZ/10 cycles) toggling every TONE_DIV cycles.
  - LOST produces continuous tone.
  - WON produces tone for 500 ms.
  - Otherwise audio=0.
- Undefined: audio tied to 0 and no tone logic is built.

Test Plan:
- Reset: hold rst 2 cycles -> tft_state=0, lives=3, ssdec_ss=1, tft_cs=1, audio=0, tft_rst=0 then 1.
- Win path: SELECT, then RIGHT, DOWN, SELECT, RIGHT, RIGHT, UP, RIGHT, UP, RIGHT.
  - Each press held at least 6 cycles with at least 3 cycles released between presses.
  - Required: tft_state=1 after SELECT, then 3 after the last press, lives=3.
- Errors: SELECT, then LEFT three times -> lives 2, 1, then tft_state=2 (LOST); a further SELECT -> state 0.
- Timeout: CLK_HZ=10, START_SEC=3; enter PLAY and wait 30 cycles -> state 2; ssdec frame shows 0:00.
- BACK: in PLAY press RIGHT, BACK, then the full M0 code -> module=1 with no life lost.
- Mid-game reset: assert rst during M1 -> next edge state 0, lives 3, timer 300; SELECT restarts at M0.
